// File: rtl/pd_task_dispatcher.sv
// pd_task_dispatcher: issues new pixel tasks and resumed threads to up to four
// RT cores, owns the thread-ID pool, per-thread stacks and the resume queue,
// and pulses Frame_done once every pixel is issued and every thread has ended.
module pd_task_dispatcher #(
    parameter int unsigned NUM_PIXELS = 307200,
    parameter logic [31:0] START_PC   = 32'h0000_0000,
    parameter logic [31:0] STACK_BASE = 32'h0001_0000,
    parameter int unsigned STACK_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Evt_valid,
    input  logic [1:0]  Evt_core_id,
    input  logic        Evt_finish,
    input  logic        Evt_context_switch,
    input  logic [5:0]  Evt_thread_id,
    input  logic [31:0] Evt_stack_pointer,
    input  logic [31:0] Evt_pc,
    output logic        Assign_valid,
    output logic [1:0]  Assigned_core_id,
    output logic [31:0] Pixel_id,
    output logic [5:0]  Thread_id,
    output logic [31:0] Stack_pointer,
    output logic [31:0] PC,
    output logic        Resume,
    output logic [3:0]  Busy_cores,
    output logic        Frame_done,
    output logic        Protocol_error
);

    // Thread-ID pool size; fixed by the 6-bit Thread_id and also the resume FIFO depth.
    localparam int NUM_THREADS = 64;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic [5:0]  tid;
        logic [31:0] sp;
        logic [31:0] pc;
    } ctx_t;

    state_e                 state_q, state_d;
    logic [3:0]             busy_q, busy_d;
    logic [NUM_THREADS-1:0] alloc_q, alloc_d;
    logic [31:0]            pix_cnt_q, pix_cnt_d;
    logic [1:0]             rr_q, rr_d;
    logic [5:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [6:0]             fifo_cnt_q, fifo_cnt_d;
    logic                   err_q, err_d;
    logic                   valid_q, valid_d;
    logic [1:0]             core_q, core_d;
    logic [31:0]            pix_q, pix_d;
    logic [5:0]             tid_q, tid_d;
    logic [31:0]            sp_q, sp_d;
    logic [31:0]            pc_q, pc_d;
    logic                   resume_q, resume_d;

    ctx_t                   fifo_mem  [NUM_THREADS];
    logic [31:0]            pixel_tab [NUM_THREADS];

    logic       active, fifo_empty, fifo_full;
    logic       core_found, id_found;
    logic [1:0] core_sel;
    logic [5:0] free_id;
    logic       do_pop, do_new, do_issue;
    ctx_t       pop_ctx;
    logic       evt_ok, evt_tid_free, do_free, do_push, err_set;
    logic       frame_done;

    assign active       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign fifo_empty   = (fifo_cnt_q == 7'd0);
    assign fifo_full    = (fifo_cnt_q == 7'(NUM_THREADS));
    assign pop_ctx      = fifo_mem[rd_ptr_q];

    // Resumed threads always go ahead of new pixels; new pixels only while in RUN.
    assign do_pop       = active && core_found && !fifo_empty;
    assign do_new       = (state_q == S_RUN) && core_found && fifo_empty && id_found
                          && (pix_cnt_q < NUM_PIXELS);
    assign do_issue     = do_pop || do_new;

    // An event from an idle core is ignored apart from raising the error flag.
    assign evt_ok       = Evt_valid && busy_q[Evt_core_id];
    assign evt_tid_free = !alloc_q[Evt_thread_id];
    assign do_free      = evt_ok && Evt_finish && !evt_tid_free;
    assign do_push      = evt_ok && !Evt_finish && Evt_context_switch && !evt_tid_free && !fifo_full;
    assign err_set      = (Evt_valid && !busy_q[Evt_core_id])
                        || (evt_ok && (Evt_finish || Evt_context_switch) && evt_tid_free)
                        || (evt_ok && !Evt_finish && Evt_context_switch && fifo_full);

    // Pick the first idle core at or after the round-robin pointer, wrapping mod 4.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        core_found = 1'b0;
        core_sel   = '0;
        for (int i = 0; i < 4; i++) begin
            if (!core_found && !busy_q[rr_q + 2'(i)]) begin
                core_found = 1'b1;
                core_sel   = rr_q + 2'(i);
            end
        end
    end

    // Find the lowest free thread ID (downward scan so the last hit is the lowest).
    always_comb begin
        id_found = 1'b0;
        free_id  = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (!alloc_q[i]) begin
                id_found = 1'b1;
                free_id  = 6'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic; Start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_RUN;
            S_RUN:   if (pix_cnt_q == NUM_PIXELS) state_d = S_DRAIN;
            S_DRAIN: if (busy_q == 4'd0 && fifo_empty && alloc_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: Frame_done is high for the single cycle spent in DONE.
    always_comb begin
        frame_done = (state_q == S_DONE);
    end

    // Next-state for the issue datapath, thread pool, resume FIFO pointers and error flag.
    always_comb begin
        busy_d     = busy_q;
        alloc_d    = alloc_q;
        pix_cnt_d  = pix_cnt_q;
        rr_d       = rr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = err_q | err_set;
        valid_d    = do_issue;
        core_d     = core_q;
        pix_d      = pix_q;
        tid_d      = tid_q;
        sp_d       = sp_q;
        pc_d       = pc_q;
        resume_d   = resume_q;
        fifo_cnt_d = fifo_cnt_q + 7'(do_push) - 7'(do_pop);

        if (evt_ok)  busy_d[Evt_core_id]    = 1'b0;
        if (do_free) alloc_d[Evt_thread_id] = 1'b0;
        if (do_push) wr_ptr_d = wr_ptr_q + 6'd1;
        if (state_q == S_IDLE && Start) pix_cnt_d = '0;

        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 6'd1;
            tid_d    = pop_ctx.tid;
            pix_d    = pixel_tab[pop_ctx.tid];
            sp_d     = pop_ctx.sp;
            pc_d     = pop_ctx.pc;
            resume_d = 1'b1;
        end else if (do_new) begin
            alloc_d[free_id] = 1'b1;
            pix_d     = pix_cnt_q;
            pix_cnt_d = pix_cnt_q + 32'd1;
            tid_d     = free_id;
            sp_d      = STACK_BASE + 32'(free_id) * STACK_SIZE;
            pc_d      = START_PC;
            resume_d  = 1'b0;
        end

        if (do_issue) begin
            busy_d[core_sel] = 1'b1;
            rr_d             = core_sel + 2'd1;
            core_d           = core_sel;
        end
    end

    // Control and output registers; reset abandons all in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            busy_q     <= '0;
            alloc_q    <= '0;
            pix_cnt_q  <= '0;
            rr_q       <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            core_q     <= '0;
            pix_q      <= '0;
            tid_q      <= '0;
            sp_q       <= '0;
            pc_q       <= '0;
            resume_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            alloc_q    <= alloc_d;
            pix_cnt_q  <= pix_cnt_d;
            rr_q       <= rr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            core_q     <= core_d;
            pix_q      <= pix_d;
            tid_q      <= tid_d;
            sp_q       <= sp_d;
            pc_q       <= pc_d;
            resume_q   <= resume_d;
        end
    end

    // Resume FIFO storage and per-thread pixel table.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; pointers and the allocation mask define validity.
        if (do_push) fifo_mem[wr_ptr_q] <= {Evt_thread_id, Evt_stack_pointer, Evt_pc};
        if (do_new)  pixel_tab[free_id] <= pix_cnt_q;
    end

    assign Assign_valid     = valid_q;
    assign Assigned_core_id = core_q;
    assign Pixel_id         = pix_q;
    assign Thread_id        = tid_q;
    assign Stack_pointer    = sp_q;
    assign PC               = pc_q;
    assign Resume           = resume_q;
    assign Busy_cores       = busy_q;
    assign Frame_done       = frame_done;
    assign Protocol_error   = err_q;

endmodule

// File: tb/tb_pd_task_dispatcher.sv
// tb_pd_task_dispatcher: directed steps plus randomized core events, checked
// every cycle against a queue-based reference model of the dispatcher.
module tb_pd_task_dispatcher;

    localparam int          N     = 12;
    localparam logic [31:0] SBASE = 32'h0001_0000;
    localparam logic [31:0] SPC   = 32'h0000_0000;
    localparam int          SSIZE = 1024;

    typedef struct {
        int          tid;
        logic [31:0] sp;
        logic [31:0] pc;
    } ctx_t;

    logic        clk = 1'b0;
    logic        rst_n, Start, Evt_valid, Evt_finish, Evt_context_switch;
    logic [1:0]  Evt_core_id;
    logic [5:0]  Evt_thread_id;
    logic [31:0] Evt_stack_pointer, Evt_pc;
    logic        Assign_valid, Resume, Frame_done, Protocol_error;
    logic [1:0]  Assigned_core_id;
    logic [31:0] Pixel_id, Stack_pointer, PC;
    logic [5:0]  Thread_id;
    logic [3:0]  Busy_cores;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit          m_busy [4];
    int          m_core_tid [4];
    bit          m_owned [64];
    logic [31:0] m_pix_of [64];
    ctx_t        m_q [$];
    int          m_next_pixel, m_rr;
    bit          m_in_frame, m_done_pulse, m_err;
    logic        e_valid, e_resume;
    logic [1:0]  e_core;
    logic [5:0]  e_tid;
    logic [31:0] e_pix, e_sp, e_pc;

    pd_task_dispatcher #(
        .NUM_PIXELS (N),
        .START_PC   (SPC),
        .STACK_BASE (SBASE),
        .STACK_SIZE (SSIZE)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .Start              (Start),
        .Evt_valid          (Evt_valid),
        .Evt_core_id        (Evt_core_id),
        .Evt_finish         (Evt_finish),
        .Evt_context_switch (Evt_context_switch),
        .Evt_thread_id      (Evt_thread_id),
        .Evt_stack_pointer  (Evt_stack_pointer),
        .Evt_pc             (Evt_pc),
        .Assign_valid       (Assign_valid),
        .Assigned_core_id   (Assigned_core_id),
        .Pixel_id           (Pixel_id),
        .Thread_id          (Thread_id),
        .Stack_pointer      (Stack_pointer),
        .PC                 (PC),
        .Resume             (Resume),
        .Busy_cores         (Busy_cores),
        .Frame_done         (Frame_done),
        .Protocol_error     (Protocol_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) begin m_busy[i] = 1'b0; m_core_tid[i] = 0; end
        foreach (m_owned[i]) m_owned[i] = 1'b0;
        m_q.delete();
        m_next_pixel = 0; m_rr = 0;
        m_in_frame = 1'b0; m_done_pulse = 1'b0; m_err = 1'b0;
        e_valid = 1'b0; e_resume = 1'b0; e_core = '0; e_tid = '0;
        e_pix = '0; e_sp = '0; e_pc = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit   evt_ok, ev_free, ev_push, ev_err, go_done, any_busy, any_owned;
        int   core, t;
        ctx_t r;
        if (!rst_n) begin
            model_reset();
            return;
        end
        evt_ok  = Evt_valid && m_busy[Evt_core_id];
        ev_err  = Evt_valid && !evt_ok;
        ev_free = 1'b0;
        ev_push = 1'b0;
        if (evt_ok) begin
            if (Evt_finish) begin
                if (m_owned[Evt_thread_id]) ev_free = 1'b1; else ev_err = 1'b1;
            end else if (Evt_context_switch) begin
                if (!m_owned[Evt_thread_id] || m_q.size() == 64) ev_err = 1'b1;
                else ev_push = 1'b1;
            end
        end
        any_busy  = m_busy[0] | m_busy[1] | m_busy[2] | m_busy[3];
        any_owned = 1'b0;
        foreach (m_owned[i]) any_owned |= m_owned[i];
        go_done = m_in_frame && m_next_pixel == N && !any_busy && m_q.size() == 0 && !any_owned;

        // Issue decision on the state before this edge's event takes effect.
        e_valid = 1'b0;
        if (m_in_frame) begin
            core = -1;
            for (int k = 0; k < 4; k++)
                if (core < 0 && !m_busy[(m_rr + k) % 4]) core = (m_rr + k) % 4;
            if (core >= 0) begin
                if (m_q.size() != 0) begin
                    r = m_q.pop_front();
                    e_valid = 1'b1; e_resume = 1'b1; e_tid = 6'(r.tid);
                    e_pix = m_pix_of[r.tid]; e_sp = r.sp; e_pc = r.pc;
                end else if (m_next_pixel < N) begin
                    t = -1;
                    for (int i = 0; i < 64; i++) if (t < 0 && !m_owned[i]) t = i;
                    if (t >= 0) begin
                        e_valid = 1'b1; e_resume = 1'b0; e_tid = 6'(t);
                        e_pix = 32'(m_next_pixel);
                        e_sp = SBASE + 32'(t * SSIZE); e_pc = SPC;
                        m_owned[t] = 1'b1; m_pix_of[t] = 32'(m_next_pixel);
                        m_next_pixel++;
                    end
                end
                if (e_valid) begin
                    e_core = 2'(core);
                    m_core_tid[core] = int'(e_tid);
                    m_rr = (core + 1) % 4;
                end
            end
        end

        if (evt_ok)  m_busy[Evt_core_id] = 1'b0;
        if (ev_free) m_owned[Evt_thread_id] = 1'b0;
        if (ev_push) m_q.push_back('{tid: int'(Evt_thread_id), sp: Evt_stack_pointer, pc: Evt_pc});
        if (e_valid) m_busy[e_core] = 1'b1;
        m_err |= ev_err;

        if (m_done_pulse) m_done_pulse = 1'b0;
        else if (go_done) begin m_done_pulse = 1'b1; m_in_frame = 1'b0; end
        else if (!m_in_frame && Start) begin m_in_frame = 1'b1; m_next_pixel = 0; end
    endtask

    task automatic compare_all();
        check("Assign_valid", 32'(Assign_valid), 32'(e_valid));
        check("Assigned_core_id", 32'(Assigned_core_id), 32'(e_core));
        check("Pixel_id", Pixel_id, e_pix);
        check("Thread_id", 32'(Thread_id), 32'(e_tid));
        check("Stack_pointer", Stack_pointer, e_sp);
        check("PC", PC, e_pc);
        check("Resume", 32'(Resume), 32'(e_resume));
        check("Busy_cores", 32'(Busy_cores), 32'({m_busy[3], m_busy[2], m_busy[1], m_busy[0]}));
        check("Frame_done", 32'(Frame_done), 32'(m_done_pulse));
        check("Protocol_error", 32'(Protocol_error), 32'(m_err));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_evt();
        Evt_valid = 1'b0; Evt_finish = 1'b0; Evt_context_switch = 1'b0;
    endtask

    // Act as the four cores: randomly finish or suspend running threads until the frame ends.
    task automatic run_until_done(input int budget);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < budget) begin
            int c, r;
            clear_evt();
            Start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) begin
                c = $urandom_range(0, 3);
                if (m_busy[c]) begin
                    Evt_valid     = 1'b1;
                    Evt_core_id   = 2'(c);
                    Evt_thread_id = 6'(m_core_tid[c]);
                    r = $urandom_range(0, 99);
                    if (r < 65) Evt_finish = 1'b1;
                    else if (r < 75) begin Evt_finish = 1'b1; Evt_context_switch = 1'b1; end
                    else begin
                        Evt_context_switch = 1'b1;
                        Evt_stack_pointer  = $urandom;
                        Evt_pc             = $urandom;
                    end
                end
            end
            tick();
            seen = m_done_pulse;
            cyc++;
        end
        clear_evt();
        Start = 1'b0;
        check("frame_done_within_budget", 32'(Frame_done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; Start = 1'b0; clear_evt();
        Evt_core_id = '0; Evt_thread_id = '0; Evt_stack_pointer = '0; Evt_pc = '0;

        // Reset state.
        tick(); tick();
        check("reset_valid", 32'(Assign_valid), 32'd0);
        check("reset_busy", 32'(Busy_cores), 32'd0);
        check("reset_error", 32'(Protocol_error), 32'd0);
        rst_n = 1'b1;
        tick();

        // Start: one empty cycle, then four strobes on consecutive cycles.
        Start = 1'b1; tick(); Start = 1'b0;
        check("start_latency_gap", 32'(Assign_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("first_valid", 32'(Assign_valid), 32'd1);
            check("first_core", 32'(Assigned_core_id), 32'(i));
            check("first_pixel", Pixel_id, 32'(i));
            check("first_tid", 32'(Thread_id), 32'(i));
            check("first_sp", Stack_pointer, 32'h0001_0000 + 32'(i) * 32'h400);
            check("first_pc", PC, 32'd0);
        end
        check("all_busy", 32'(Busy_cores), 32'hF);

        // Core 2 finishes thread 2; next cycle it receives thread 2 with pixel 4.
        Evt_valid = 1'b1; Evt_core_id = 2'd2; Evt_finish = 1'b1; Evt_thread_id = 6'd2;
        tick(); clear_evt();
        tick();
        check("reuse_core", 32'(Assigned_core_id), 32'd2);
        check("reuse_tid", 32'(Thread_id), 32'd2);
        check("reuse_pixel", Pixel_id, 32'd4);
        check("reuse_sp", Stack_pointer, 32'h0001_0800);
        check("reuse_resume", 32'(Resume), 32'd0);

        // Core 1 suspends thread 1; it is resumed before any new pixel.
        Evt_valid = 1'b1; Evt_core_id = 2'd1; Evt_context_switch = 1'b1; Evt_thread_id = 6'd1;
        Evt_stack_pointer = 32'h0001_04F0; Evt_pc = 32'h0000_0200;
        tick(); clear_evt();
        tick();
        check("resume_valid", 32'(Assign_valid), 32'd1);
        check("resume_core", 32'(Assigned_core_id), 32'd1);
        check("resume_flag", 32'(Resume), 32'd1);
        check("resume_tid", 32'(Thread_id), 32'd1);
        check("resume_pixel", Pixel_id, 32'd1);
        check("resume_sp", Stack_pointer, 32'h0001_04F0);
        check("resume_pc", PC, 32'h0000_0200);

        // Finish the frame with random events; Frame_done must follow and clear.
        run_until_done(3000);
        tick();
        check("frame_done_one_cycle", 32'(Frame_done), 32'd0);

        // Restart from IDLE: pixel 0 with thread 0 again.
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        check("restart_valid", 32'(Assign_valid), 32'd1);
        check("restart_pixel", Pixel_id, 32'd0);
        check("restart_tid", 32'(Thread_id), 32'd0);
        run_until_done(3000);
        tick();
        Start = 1'b1; tick(); Start = 1'b0;
        run_until_done(3000);
        tick();

        // Event from an idle core: sticky error, nothing else changes.
        Evt_valid = 1'b1; Evt_core_id = 2'd0; Evt_finish = 1'b1; Evt_thread_id = 6'd5;
        tick(); clear_evt();
        check("idle_evt_error", 32'(Protocol_error), 32'd1);
        check("idle_evt_busy", 32'(Busy_cores), 32'd0);
        tick(); tick(); tick();
        check("error_sticky", 32'(Protocol_error), 32'd1);

        // Mid-frame: a flagless event only frees the core; then reset abandons the frame.
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Evt_valid = 1'b1; Evt_core_id = 2'd0; Evt_thread_id = 6'(m_core_tid[0]);
        tick(); clear_evt();
        check("flagless_busy_clear", 32'(Busy_cores[0]), 32'd0);
        rst_n = 1'b0; tick();
        check("midreset_valid", 32'(Assign_valid), 32'd0);
        check("midreset_pixel", Pixel_id, 32'd0);
        check("midreset_sp", Stack_pointer, 32'd0);
        check("midreset_busy", 32'(Busy_cores), 32'd0);
        check("midreset_error", 32'(Protocol_error), 32'd0);
        rst_n = 1'b1; tick();
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        check("after_reset_valid", 32'(Assign_valid), 32'd1);
        check("after_reset_core", 32'(Assigned_core_id), 32'd0);
        check("after_reset_pixel", Pixel_id, 32'd0);
        check("after_reset_tid", 32'(Thread_id), 32'd0);
        for (int i = 0; i < 3; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
